// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions, store-size encodings and serializer states.
package uart_pkg;

  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_BAUD   = 4'h8;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 8;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU data-memory responder bus: load/store strobes, offset, store data,
// access size and combinational load data.
interface mmio_uart_tx_if;

  logic        cs;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic [31:0] rdata;

  modport master (
    output cs, mem_read, mem_write, addr, wdata, funct3,
    input  rdata
  );

  modport slave (
    input  cs, mem_read, mem_write, addr, wdata, funct3,
    output rdata
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap bit
// so full and empty are distinguished by the MSB compare.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]      wptr_q, rptr_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO and a
// serializer FSM driving a registered tx line.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DEFAULT_DIV = 868
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mmio_uart_tx_if.slave bus_if,
  output logic          tx_o,
  output logic          tx_busy_o
);

  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DefDiv = 16'(DEFAULT_DIV);

  logic [3:0]      reg_addr;
  logic            wr_txdata, wr_status, wr_baud, byte_st;
  logic [15:0]     baud_q, baud_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      fifo_rdata;
  logic            fifo_full, fifo_empty, pop;
  logic [CntW-1:0] fifo_count;
  logic [31:0]     status, rdata;
  logic            unused_bits;

  uart_state_e state_q;
  logic        tx_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic [15:0] cnt_q, div_q;
  logic        bit_end;

  assign reg_addr  = {bus_if.addr[3:2], 2'b00};
  assign wr_txdata = bus_if.cs && bus_if.mem_write && (reg_addr == UART_TXDATA);
  assign wr_status = bus_if.cs && bus_if.mem_write && (reg_addr == UART_STATUS);
  assign wr_baud   = bus_if.cs && bus_if.mem_write && (reg_addr == UART_BAUD);
  assign byte_st   = (bus_if.funct3 == F3_SB);
  assign unused_bits = ^{bus_if.wdata[31:16], bus_if.addr[1:0]};

  always_comb begin
    baud_d = baud_q;
    if (wr_baud) begin
      baud_d = byte_st ? {baud_q[15:8], bus_if.wdata[7:0]} : bus_if.wdata[15:0];
      if (baud_d == '0) baud_d = 16'd1;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_status && bus_if.wdata[STAT_OVF]) begin
      ovf_d = 1'b0;
    end else if (wr_txdata && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      baud_q <= DefDiv;
      ovf_q  <= 1'b0;
    end else begin
      baud_q <= baud_d;
      ovf_q  <= ovf_d;
    end
  end

  sync_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (wr_txdata),
    .wdata_i (bus_if.wdata[7:0]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bit_end = (cnt_q == div_q - 16'd1);
  assign pop     = !fifo_empty && ((state_q == StIdle) || ((state_q == StStop) && bit_end));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      div_q     <= DefDiv;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            shift_q <= fifo_rdata;
            div_q   <= baud_q;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (bit_end) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= StData;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StData: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              // tx takes the next bit now so it lines up with the shifted register
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StStop: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (!fifo_empty) begin
              shift_q <= fifo_rdata;
              div_q   <= baud_q;
              tx_q    <= 1'b0;
              state_q <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tx_o      = tx_q;
  assign tx_busy_o = (state_q != StIdle) || !fifo_empty;

  always_comb begin
    status = '0;
    status[STAT_BUSY]  = tx_busy_o;
    status[STAT_FULL]  = fifo_full;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_OVF]   = ovf_q;
    status[STAT_CNT_LSB +: 4] = 4'(fifo_count);
  end

  always_comb begin
    rdata = '0;
    if (bus_if.cs && bus_if.mem_read) begin
      case (reg_addr)
        UART_STATUS: rdata = status;
        UART_BAUD:   rdata = {16'h0, baud_q};
        default:     rdata = '0;
      endcase
    end
  end

  assign bus_if.rdata = rdata;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame timing and bit
// order, back-to-back frames, overflow, baud latching and mid-frame reset.
module tb_mmio_uart_tx;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic tx, tx_busy;
  int   checks = 0;
  int   errors = 0;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (868)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .bus_if    (bus),
    .tx_o      (tx),
    .tx_busy_o (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.cs = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.addr = 4'h0; bus.wdata = 32'h0; bus.funct3 = F3_SW;
  endtask

  task automatic set_wr(input logic [3:0] a, input logic [31:0] d);
    bus.cs = 1'b1; bus.mem_read = 1'b0; bus.mem_write = 1'b1;
    bus.addr = a; bus.wdata = d; bus.funct3 = F3_SW;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    set_wr(a, d);
    tick();
    idle_bus();
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus.cs = 1'b1; bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.addr = a;
    #1;
    d = bus.rdata;
    idle_bus();
  endtask

  // Samples one frame starting now; optionally issues a store at cycle wr_at.
  task automatic frame(input int div, input int wr_at, input logic [3:0] wa,
                       input logic [31:0] wd, output logic [9:0] obs,
                       output int unstable, output logic busy_last);
    unstable  = 0;
    obs       = '0;
    busy_last = 1'b0;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < div; k++) begin
        int idx;
        idx = b * div + k;
        if (k == 0) obs[b] = tx;
        else if (tx !== obs[b]) unstable++;
        busy_last = tx_busy;
        if (idx == wr_at) set_wr(wa, wd);
        tick();
        if (idx == wr_at) idle_bus();
      end
    end
  endtask

  logic [31:0] r;
  logic [9:0]  obs;
  int          unst;
  logic        bl;
  int          lows;

  initial begin
    idle_bus();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state and read decode
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    bus.cs = 1'b1; bus.addr = UART_STATUS; #1;
    check("rdata_no_read", bus.rdata, 0);
    idle_bus(); bus.mem_read = 1'b1; bus.addr = UART_STATUS; #1;
    check("rdata_no_cs", bus.rdata, 0);
    idle_bus();
    rd(UART_STATUS, r); check("rst_status", r, 32'h4);
    rd(UART_BAUD, r);   check("rst_baud", r, 32'd868);
    rd(4'hC, r);        check("rd_reserved", r, 0);
    rd(UART_TXDATA, r); check("rd_txdata", r, 0);

    // Single frame, 4 cycles/bit, 0xA5
    wr(UART_BAUD, 32'd4);
    wr(UART_TXDATA, 32'hA5);
    rd(UART_STATUS, r); check("a5_status", r, 32'h101);
    check("a5_tx_n1", tx, 1);
    tick();
    frame(4, -1, 4'h0, 32'h0, obs, unst, bl);
    check("a5_frame", obs, 10'h34A);
    check("a5_stable", unst, 0);
    check("a5_busy_last", bl, 1);
    check("a5_busy_end", tx_busy, 0);

    // Back-to-back frames at 2 cycles/bit
    wr(UART_BAUD, 32'd2);
    wr(UART_TXDATA, 32'h55);
    wr(UART_TXDATA, 32'h0F);
    frame(2, -1, 4'h0, 32'h0, obs, unst, bl);
    check("b2b_frame0", obs, 10'h2AA);
    check("b2b_stable0", unst, 0);
    frame(2, -1, 4'h0, 32'h0, obs, unst, bl);
    check("b2b_frame1", obs, 10'h21E);
    check("b2b_stable1", unst, 0);
    check("b2b_busy_end", tx_busy, 0);

    // Fill, overflow, sticky clear
    wr(UART_BAUD, 32'd100);
    for (int i = 0; i < 9; i++) wr(UART_TXDATA, 32'h10 + i);
    rd(UART_STATUS, r); check("fill_status", r, 32'h803);
    wr(UART_TXDATA, 32'hEE);
    rd(UART_STATUS, r); check("ovf_status", r, 32'h80B);
    wr(UART_STATUS, 32'hFFFF_FFF7);
    rd(UART_STATUS, r); check("ovf_keep", r, 32'h80B);
    wr(UART_STATUS, 32'h8);
    rd(UART_STATUS, r); check("ovf_clear", r, 32'h803);
    rst = 1'b1; tick(); rst = 1'b0;
    rd(UART_STATUS, r); check("rst2_status", r, 32'h4);
    rd(UART_BAUD, r);   check("rst2_baud", r, 32'd868);

    // BAUD width, zero write, 1 cycle/bit
    wr(UART_BAUD, 32'hABCD_1234);
    rd(UART_BAUD, r); check("baud_upper", r, 32'h1234);
    wr(UART_BAUD, 32'h0);
    rd(UART_BAUD, r); check("baud_zero", r, 32'h1);
    wr(UART_TXDATA, 32'hC3);
    check("c3_tx_n1", tx, 1);
    tick();
    frame(1, -1, 4'h0, 32'h0, obs, unst, bl);
    check("c3_frame", obs, 10'h386);
    check("c3_busy_end", tx_busy, 0);

    // BAUD change mid-frame applies to the next frame only
    wr(UART_BAUD, 32'd3);
    wr(UART_TXDATA, 32'h3C);
    wr(UART_TXDATA, 32'h81);
    frame(3, 5, UART_BAUD, 32'd6, obs, unst, bl);
    check("div3_frame", obs, 10'h278);
    check("div3_stable", unst, 0);
    frame(6, -1, 4'h0, 32'h0, obs, unst, bl);
    check("div6_frame", obs, 10'h302);
    check("div6_stable", unst, 0);
    check("div6_busy_end", tx_busy, 0);

    // Reset mid-DATA with three bytes queued
    wr(UART_BAUD, 32'd2);
    for (int i = 0; i < 4; i++) wr(UART_TXDATA, 32'hF0 + i);
    tick(); tick();
    check("mid_tx_low", tx, 0);
    rd(UART_STATUS, r); check("mid_status", r, 32'h301);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_tx", tx, 1);
    rd(UART_STATUS, r); check("mid_rst_status", r, 32'h4);
    lows = 0;
    repeat (60) begin
      if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
      tick();
    end
    check("mid_rst_quiet", lows, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that acts as a responder on the CPU data-memory interface: same mem_read/mem_write, address, store-data and funct3 signalling as Data_Memory.
- The top-level decoder asserts cs for the peripheral's address window.
- Stores to TXDATA push bytes into a FIFO. A serializer FSM drains the FIFO onto the tx pin as 8N1 frames at a programmable baud divisor.
- Loads return status combinationally, which is single-cycle compatible.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, minimum 2.
- DEFAULT_DIV, 868, reset value of BAUD_DIV in clk cycles per bit (100 MHz / 115200).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cs  in  1  peripheral selected, from address decode
- mem_read  in  1  load strobe
- mem_write  in  1  store strobe
- addr  in  4  byte offset within window (alu_result[3:0])
- wdata  in  32  store data (rs2_data)
- funct3  in  3  access size; only SW and SB honoured, SH treated as SW
- rdata  out  32  load data, combinational
- tx  out  1  serial line, idle high
- tx_busy  out  1  FSM not IDLE or FIFO not empty

Behaviour:
- Register map (word offsets):
  - 0x0 TXDATA: W pushes wdata[7:0]; R returns 0.
  - 0x4 STATUS (R):
    - bit0 busy
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - bits[11:8] fifo count
  - 0x4 STATUS (W): writing 1 to bit3 clears overflow; other bits ignored.
  - 0x8 BAUD_DIV: RW, bits[15:0]; upper bits read 0; a write of 0 stores 1.
  - 0xC: reads 0, writes ignored.
- Access rules:
  - All accesses require cs. addr[1:0] is ignored.
  - rdata = 0 when cs=0 or mem_read=0.
  - Loads have no side effects.
- Reset values:
  - tx=1, tx_busy=0, rdata=0 (no read active)
  - FIFO empty, count=0, overflow=0
  - BAUD_DIV=DEFAULT_DIV, FSM=IDLE
- Push:
  - A store to 0x0 in cycle N writes the FIFO on the clk edge ending N; count is visible in cycle N+1.
  - Push while full (and no pop that same cycle): byte dropped, overflow set.
  - Simultaneous push and pop when full: both take effect, count unchanged, no overflow.
- FIFO: circular buffer with read/write pointers of log2(FIFO_DEPTH)+1 bits; wrap is handled by the MSB compare.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If FIFO non-empty: pop into shift register, latch BAUD_DIV into div_q, clear baud counter, go to START.
  - Result: tx low in cycle N+2 after the store in cycle N, given IDLE.
- START: tx=0 for div_q cycles, then go to DATA with bit_idx=0.
- DATA:
  - tx = shift[0] for div_q cycles per bit, LSB first.
  - Shift right and increment bit_idx at each bit end; after bit 7, go to STOP.
- STOP: tx=1 for div_q cycles. At the end, if FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Frame length = 10*div_q cycles exactly.
- Baud counter:
  - Counts 0..div_q-1; the bit ends when the counter == div_q-1.
  - div_q=1 gives one cycle per bit.
- BAUD_DIV writes mid-frame do not affect the current frame; the new value is latched at the next frame start.
- tx is registered (driven from a flop, no glitches).
- rst mid-frame: tx returns to 1 on the next edge, FIFO contents are discarded, and no partial frame completes.

Decomposition:
- Shared package (uart_pkg):
  - register offset constants UART_TXDATA=4'h0, UART_STATUS=4'h4, UART_BAUD=4'h8
  - STATUS bit index constants
  - FSM state enum (2-bit)
- Sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count) holds the buffering. The top holds the register decode and the serializer FSM.

Test Plan:
- Reset, then read STATUS -> rdata=0x0000_0004 (empty); BAUD read -> 868; tx=1.
- BAUD=4, store 0xA5 to TXDATA -> tx low at N+2 for 4 cycles; data bits 1,0,1,0,0,1,0,1 for 4 cycles each; stop high for 4 cycles; tx_busy drops after 40 cycles.
- BAUD=2, push 0x55 then 0x0F on consecutive cycles -> two frames back-to-back, the second start bit begins exactly 20 cycles after the first, with no idle cycle.
- BAUD=100, push 9 bytes with FIFO_DEPTH=8 while the first frame is active -> one pop frees a slot, so all are accepted; a 10th push while full -> overflow=1, byte dropped, count=8. Write 0x8 to STATUS -> overflow=0.
- Write BAUD=0 -> reads back 1, frames run at 1 cycle/bit. Change BAUD from 3 to 6 mid-frame -> current frame stays at 3 cycles/bit, the next frame uses 6.
- Assert rst mid-DATA with 3 bytes queued -> tx=1 next cycle, STATUS=0x4, no further frames.
